multi_host_reg_bank: RTL and testbench

Parametrised register bank shared by up to `NUM_HOSTS` serial-peripheral front-ends, such as SPI and I2C, through a registered request/acknowledge handshake. Fair round-robin arbitration replaces the static peripheral select mux. Out-of-range accesses and writes to read-only registers are decoded on the full address width and flagged with an error response. A per-register write strobe is provided for downstream logic. The block sits between the peripheral front-ends and the design core, exposing `rw_regs` and consuming `ro_regs`.

---
 rtl/multi_host_reg_bank_pkg.sv | 20 ++
 rtl/multi_host_reg_bank_if.sv | 29 ++
 rtl/multi_host_reg_bank_rr_arbiter.sv | 36 +++
 rtl/multi_host_reg_bank.sv | 142 ++++++++++++++
 tb/tb_multi_host_reg_bank.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_host_reg_bank_pkg.sv
// Shared types for the multi-host register bank.
// Imported by the arbiter, the interface users and the top.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

  function automatic int host_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_host_reg_bank_if.sv
// Host-side request/acknowledge bundle of the register bank.
// Hosts drive the master side, the bank the slave side.
interface multi_host_reg_bank_if #(
  parameter int NUM_HOSTS  = 2,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
);

  logic                            ena;
  logic [NUM_HOSTS-1:0]            req;
  logic [NUM_HOSTS-1:0]            wr_rdn;
  logic [NUM_HOSTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_HOSTS*REG_WIDTH-1:0]  wdata;
  logic [NUM_HOSTS-1:0]            ack;
  logic [NUM_HOSTS-1:0]            err;
  logic [REG_WIDTH-1:0]            rdata;
  logic                            busy;

  modport master (
    output ena, req, wr_rdn, addr, wdata,
    input  ack, err, rdata, busy
  );

  modport slave (
    input  ena, req, wr_rdn, addr, wdata,
    output ack, err, rdata, busy
  );

endinterface

// File: rtl/multi_host_reg_bank_rr_arbiter.sv
// Combinational round-robin picker; the parent holds last_grant.
// Search begins one past the previous winner.
module rr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = host_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;

  assign dbl = {req, req};
  assign rot = dbl >> (int'(last_grant) + 1);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !valid && rot[k]) begin
        valid     = 1'b1;
        grant_idx = IW'((int'(last_grant) + 1 + k) % N);
      end
    end
    grant = N'(valid) << grant_idx;
  end

endmodule

// File: rtl/multi_host_reg_bank.sv
// Register bank shared by several hosts through a 3-state
// request/ack FSM with round-robin arbitration.
module multi_host_reg_bank
  import reg_bank_pkg::*;
#(
  parameter int NUM_HOSTS  = 2,
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  multi_host_reg_bank_if.slave            bus,
  output logic [NUM_CFG*REG_WIDTH-1:0]    rw_regs,
  output logic [NUM_CFG-1:0]              cfg_wr,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] ro_regs
);

  localparam int IW = host_idx_w(NUM_HOSTS);
  localparam int AW = ADDR_WIDTH;
  localparam int RW = REG_WIDTH;

  state_t               state;
  op_t                  op_q;
  logic [NUM_HOSTS-1:0] win_q;
  logic [AW-1:0]        addr_q;
  logic [RW-1:0]        wdata_q;
  logic [IW-1:0]        last_grant;
  logic [RW-1:0]        cfg_q [NUM_CFG];

  logic [NUM_HOSTS-1:0] grant;
  logic [IW-1:0]        g_idx;
  logic                 g_valid;

  logic                 hit_cfg;
  logic                 hit_ro;
  logic                 bad;
  logic [NUM_CFG-1:0]   cfg_sel;
  logic [RW-1:0]        rd_val;

  rr_arbiter #(
    .N  (NUM_HOSTS),
    .IW (IW)
  ) u_arb (
    .req        (bus.req),
    .last_grant (last_grant),
    .en         (bus.ena && state == IDLE),
    .grant      (grant),
    .grant_idx  (g_idx),
    .valid      (g_valid)
  );

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_rw
    assign rw_regs[k*RW +: RW] = cfg_q[k];
  end

  // Full-width compare so high address bits never alias low registers
  always_comb begin
    hit_cfg = 1'b0;
    hit_ro  = 1'b0;
    cfg_sel = '0;
    rd_val  = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (int'(addr_q) == k) begin
        hit_cfg    = 1'b1;
        cfg_sel[k] = 1'b1;
        rd_val     = cfg_q[k];
      end
    end
    for (int k = 0; k < NUM_STATUS; k++) begin
      if (int'(addr_q) == NUM_CFG + k) begin
        hit_ro = 1'b1;
        rd_val = ro_regs[k*RW +: RW];
      end
    end
    bad = (op_q == WRITE) ? !hit_cfg
                          : !(hit_cfg || hit_ro);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= READ;
      win_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_grant <= IW'(NUM_HOSTS - 1);
      bus.ack    <= '0;
      bus.err    <= '0;
      bus.rdata  <= '0;
      bus.busy   <= 1'b0;
      cfg_wr     <= '0;
      for (int k = 0; k < NUM_CFG; k++)
        cfg_q[k] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.ack <= '0;
          bus.err <= '0;
          cfg_wr  <= '0;
          if (g_valid) begin
            state      <= ACCESS;
            bus.busy   <= 1'b1;
            win_q      <= grant;
            last_grant <= g_idx;
            for (int i = 0; i < NUM_HOSTS; i++) begin
              if (grant[i]) begin
                op_q    <= op_t'(bus.wr_rdn[i]);
                addr_q  <= bus.addr[i*AW +: AW];
                wdata_q <= bus.wdata[i*RW +: RW];
              end
            end
          end
        end
        ACCESS: begin
          state   <= RESP;
          bus.ack <= win_q;
          bus.err <= bad ? win_q : '0;
          if (bad) begin
            bus.rdata <= '0;
          end else if (op_q == READ) begin
            bus.rdata <= rd_val;
          end else begin
            cfg_wr <= cfg_sel;
            for (int k = 0; k < NUM_CFG; k++)
              if (cfg_sel[k]) cfg_q[k] <= wdata_q;
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.ack  <= '0;
          bus.err  <= '0;
          cfg_wr   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_host_reg_bank.sv
// Directed bench: two-host bank for access/error/ena/reset cases,
// three-host bank for rotation across a gap in the requesters.
module tb_multi_host_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  multi_host_reg_bank_if #(
    .NUM_HOSTS(2), .REG_WIDTH(8), .ADDR_WIDTH(8)
  ) bus2 ();
  multi_host_reg_bank_if #(
    .NUM_HOSTS(3), .REG_WIDTH(8), .ADDR_WIDTH(8)
  ) bus3 ();

  logic [63:0] rw2, ro2, rw3, ro3;
  logic [7:0]  cw2, cw3;

  multi_host_reg_bank #(
    .NUM_HOSTS(2), .NUM_CFG(8), .NUM_STATUS(8),
    .REG_WIDTH(8), .ADDR_WIDTH(8)
  ) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2),
    .rw_regs (rw2),
    .cfg_wr  (cw2),
    .ro_regs (ro2)
  );

  multi_host_reg_bank #(
    .NUM_HOSTS(3), .NUM_CFG(8), .NUM_STATUS(8),
    .REG_WIDTH(8), .ADDR_WIDTH(8)
  ) dut3 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus3),
    .rw_regs (rw3),
    .cfg_wr  (cw3),
    .ro_regs (ro3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int h, input bit wr,
                     input logic [7:0] a,
                     input logic [7:0] d,
                     input bit e_err, input bit ck_rd,
                     input logic [7:0] e_rd,
                     input logic [63:0] e_rw,
                     input logic [7:0] e_cw);
    logic [1:0] eack;
    eack = 2'b01 << h;
    bus2.req[h]          = 1'b1;
    bus2.wr_rdn[h]       = wr;
    bus2.addr[h*8 +: 8]  = a;
    bus2.wdata[h*8 +: 8] = d;
    cyc();
    chk("access_busy", bus2.busy, 1);
    chk("access_noack", bus2.ack, 0);
    cyc();
    chk("resp_ack", bus2.ack, eack);
    chk("resp_err", bus2.err, e_err ? eack : 2'b00);
    if (ck_rd) chk("resp_rdata", bus2.rdata, e_rd);
    chk("resp_rw", rw2, e_rw);
    chk("resp_cfgwr", cw2, e_cw);
    bus2.req[h] = 1'b0;
    cyc();
    chk("idle_ack", bus2.ack, 0);
    chk("idle_cfgwr", cw2, 0);
    chk("idle_busy", bus2.busy, 0);
  endtask

  logic [1:0] ea2;
  logic [2:0] ea3;
  bit         seen;

  initial begin
    rst         = 1'b1;
    bus2.ena    = 1'b1;
    bus2.req    = '0;
    bus2.wr_rdn = '0;
    bus2.addr   = '0;
    bus2.wdata  = '0;
    bus3.ena    = 1'b1;
    bus3.req    = '0;
    bus3.wr_rdn = '0;
    bus3.addr   = '0;
    bus3.wdata  = '0;
    ro2         = '0;
    ro3         = '0;
    cyc();
    cyc();
    chk("rst_ack", bus2.ack, 0);
    chk("rst_err", bus2.err, 0);
    chk("rst_rdata", bus2.rdata, 0);
    chk("rst_busy", bus2.busy, 0);
    chk("rst_rw", rw2, 0);
    chk("rst_cfgwr", cw2, 0);
    chk("rst3_ack", bus3.ack, 0);
    chk("rst3_busy", bus3.busy, 0);
    rst = 1'b0;
    cyc();

    txn(0, 1'b1, 8'd3, 8'hA5, 1'b0, 1'b1, 8'h00,
        64'h0000_0000_A500_0000, 8'h08);

    ro2 = 64'h0000_0000_005C_0000;
    txn(1, 1'b0, 8'd10, 8'h00, 1'b0, 1'b1, 8'h5C,
        64'h0000_0000_A500_0000, 8'h00);

    txn(0, 1'b1, 8'd9, 8'hFF, 1'b1, 1'b1, 8'h00,
        64'h0000_0000_A500_0000, 8'h00);

    txn(0, 1'b1, 8'd0, 8'h11, 1'b0, 1'b0, 8'h00,
        64'h0000_0000_A500_0011, 8'h01);

    txn(0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 8'h00,
        64'h0000_0000_A500_0011, 8'h00);

    txn(0, 1'b0, 8'h83, 8'h00, 1'b1, 1'b1, 8'h00,
        64'h0000_0000_A500_0011, 8'h00);

    txn(1, 1'b0, 8'd3, 8'h00, 1'b0, 1'b1, 8'hA5,
        64'h0000_0000_A500_0011, 8'h00);

    // both hosts hold req: grants alternate, acks 3 cycles apart
    bus2.wr_rdn = 2'b00;
    bus2.addr   = {8'd3, 8'd3};
    bus2.req    = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      ea2 = (i == 2 || i == 8)  ? 2'b01 :
            (i == 5 || i == 11) ? 2'b10 : 2'b00;
      chk($sformatf("rr2_ack_c%0d", i), bus2.ack, ea2);
    end
    bus2.req = 2'b00;
    cyc();
    cyc();

    // hosts 0 and 2 only: host 1 is skipped
    bus3.req = 3'b101;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      ea3 = (i == 2 || i == 8) ? 3'b001 :
            (i == 5)           ? 3'b100 : 3'b000;
      chk($sformatf("rr3_ack_c%0d", i), bus3.ack, ea3);
    end
    bus3.req = 3'b000;
    cyc();
    cyc();

    bus2.ena       = 1'b0;
    bus2.wr_rdn[0] = 1'b0;
    bus2.addr[7:0] = 8'd3;
    bus2.req[0]    = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus2.ack != 2'b00 || bus2.busy) seen = 1'b1;
    end
    chk("ena_low_noack", seen, 0);
    bus2.ena = 1'b1;
    cyc();
    chk("ena_access_busy", bus2.busy, 1);
    bus2.ena = 1'b0;
    cyc();
    chk("ena_drop_ack", bus2.ack, 2'b01);
    chk("ena_drop_rdata", bus2.rdata, 8'hA5);
    chk("ena_drop_err", bus2.err, 0);
    bus2.req[0] = 1'b0;
    cyc();
    chk("ena_drop_idle", bus2.ack, 0);
    bus2.ena = 1'b1;

    bus2.wr_rdn[0]  = 1'b1;
    bus2.addr[7:0]  = 8'd5;
    bus2.wdata[7:0] = 8'h77;
    bus2.req[0]     = 1'b1;
    cyc();
    chk("mid_busy", bus2.busy, 1);
    rst = 1'b1;
    cyc();
    chk("mid_ack", bus2.ack, 0);
    chk("mid_busy0", bus2.busy, 0);
    chk("mid_rw", rw2, 0);
    chk("mid_cfgwr", cw2, 0);
    chk("mid_rdata", bus2.rdata, 0);
    rst         = 1'b0;
    bus2.req[0] = 1'b0;
    cyc();
    chk("mid_after_ack", bus2.ack, 0);
    chk("mid_after_rw", rw2, 0);

    txn(1, 1'b1, 8'd5, 8'h77, 1'b0, 1'b0, 8'h00,
        64'h0000_7700_0000_0000, 8'h20);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
